// File: rtl/ctrl_iseq.sv
// ctrl_iseq: instruction sequencer feeding ctrl_top's instr_word/iw_valid port.
// On each accepted sample strobe it issues mem[0..n-1] one word at a time, waiting
// for ctrl_top's ptr_req between stages, then pulses done.
// Optional feature macro: CTRL_ISEQ_TIMEOUT_EN (WAIT-state watchdog).
module ctrl_iseq #(
    parameter int REGFILE_ADDR_WIDTH = 3,
    parameter int DATA_ADDR_WIDTH    = 4,
    parameter int PC_WIDTH           = 3,
    parameter int TIMEOUT_CYCLES     = 255,
    localparam int IW = 2 + 2*REGFILE_ADDR_WIDTH + 4*DATA_ADDR_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                prog_we_i,
    input  logic [PC_WIDTH-1:0] prog_addr_i,
    input  logic [IW-1:0]       prog_data_i,
    input  logic [PC_WIDTH:0]   stage_cnt_i,
    input  logic                smp_strobe_i,
    input  logic                ptr_req_i,
    input  logic                ovr_clr_i,
    output logic [IW-1:0]       instr_word_o,
    output logic                iw_valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                overrun_o,
    output logic                timeout_o
);

    localparam int PROG_DEPTH = 2**PC_WIDTH;
    localparam logic [PC_WIDTH:0] DEPTH_C = (PC_WIDTH+1)'(PROG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH:0]   n_q, n_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic                ovr_q, ovr_d;
    logic [IW-1:0]       mem_q [PROG_DEPTH];

    logic                launch;
    logic                last_stage;

    assign launch     = smp_strobe_i && en_i && (stage_cnt_i != '0);
    assign last_stage = ({1'b0, pc_q} == (n_q - 1'b1));

`ifdef CTRL_ISEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;
`endif

    // Next-state, datapath and sticky-flag logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        instr_d = instr_q;
        ovr_d   = ovr_q;
`ifdef CTRL_ISEQ_TIMEOUT_EN
        wd_d    = wd_q;
        tmo_d   = tmo_q;
        if (ovr_clr_i) tmo_d = 1'b0;
`endif
        // Clear first so a concurrent set wins
        if (ovr_clr_i) ovr_d = 1'b0;
        if (smp_strobe_i && (state_q != IDLE)) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    n_d     = (stage_cnt_i > DEPTH_C) ? DEPTH_C : stage_cnt_i;
                    pc_d    = '0;
                    // Reads the pre-write word when a write to addr 0 lands this cycle
                    instr_d = mem_q[0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
`ifdef CTRL_ISEQ_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            WAIT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (ptr_req_i) begin
                    if (last_stage) begin
                        state_d = FIN;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        instr_d = mem_q[pc_q + 1'b1];
                        state_d = ISSUE;
                    end
                end
`ifdef CTRL_ISEQ_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            n_q     <= '0;
            instr_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            instr_q <= instr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef CTRL_ISEQ_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Instruction memory: not reset, writable only while idle
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == IDLE)) mem_q[prog_addr_i] <= prog_data_i;
    end

    assign instr_word_o = instr_q;
    assign iw_valid_o   = (state_q == ISSUE);
    assign done_o       = (state_q == FIN);
    assign busy_o       = (state_q != IDLE);
    assign pc_o         = pc_q;
    assign overrun_o    = ovr_q;

endmodule
